// File: rtl/valid_bitvector_pkg.sv
// Shared typedefs for the valid-bitvector slot tracker and its in-order drain.
package valid_bitvector_pkg;

  typedef enum logic {
    WAIT    = 1'b0,
    PRESENT = 1'b1
  } drain_state_e;

endpackage

// File: rtl/inorder_bitvector_drain.sv
// Drains set slots of a valid bitvector strictly in index order from a head pointer,
// presenting each slot to a consumer and pulsing a clear back to the writer on accept.
module inorder_bitvector_drain
  import valid_bitvector_pkg::*;
#(
  parameter int BITVECTOR_SIZE    = 64,
  parameter int BITVECTOR_INDEX_W = $clog2(BITVECTOR_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BITVECTOR_SIZE-1:0]    valid_bitvector,
  output logic                         clear_val,
  output logic [BITVECTOR_INDEX_W-1:0] clear_index,
  output logic                         drain_val,
  output logic [BITVECTOR_INDEX_W-1:0] drain_index,
  input  logic                         drain_rdy,
  input  logic                         restart_val,
  input  logic [BITVECTOR_INDEX_W-1:0] restart_index,
  output logic [BITVECTOR_INDEX_W-1:0] head_ptr,
  output logic                         head_wrap
);

  localparam logic [BITVECTOR_INDEX_W-1:0] LAST_SLOT = BITVECTOR_INDEX_W'(BITVECTOR_SIZE - 1);
  localparam logic [BITVECTOR_INDEX_W:0]   SIZE_EXT  = (BITVECTOR_INDEX_W + 1)'(BITVECTOR_SIZE);

  drain_state_e                 state;
  drain_state_e                 next_state;
  logic [BITVECTOR_INDEX_W-1:0] head;
  logic                         wrap;
  logic [BITVECTOR_INDEX_W-1:0] drain_slot;
  logic [BITVECTOR_INDEX_W-1:0] head_inc;
  logic [BITVECTOR_INDEX_W-1:0] restart_head;
  logic                         head_bit;
  logic                         at_last;

  assign head_bit     = valid_bitvector[head];
  assign at_last      = (head == LAST_SLOT);
  // Explicit wrap: the index width may cover more values than there are slots.
  assign head_inc     = at_last ? '0 : head + BITVECTOR_INDEX_W'(1);
  assign restart_head = ({1'b0, restart_index} >= SIZE_EXT) ? '0 : restart_index;

  always_ff @(posedge clk) begin
    if (!rst) state <= WAIT;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (restart_val) begin
      next_state = WAIT;
    end else begin
      case (state)
        WAIT:    if (head_bit)  next_state = PRESENT;
        PRESENT: if (drain_rdy) next_state = WAIT;
        default: next_state = WAIT;
      endcase
    end
  end

  // Outputs are gated by rst so nothing is presented or cleared in a reset cycle.
  always_comb begin
    drain_val   = rst && (state == PRESENT);
    clear_val   = drain_val && drain_rdy && !restart_val;
    clear_index = drain_slot;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      wrap       <= 1'b0;
      drain_slot <= '0;
    end else if (restart_val) begin
      head <= restart_head;
      wrap <= 1'b0;
    end else begin
      if (clear_val) begin
        head <= head_inc;
        if (at_last) wrap <= ~wrap;
      end
      if (state == WAIT && head_bit) drain_slot <= head;
    end
  end

  assign drain_index = drain_slot;
  assign head_ptr    = head;
  assign head_wrap   = wrap;

endmodule

// File: tb/tb_inorder_bitvector_drain.sv
// Directed bench for inorder_bitvector_drain: a 64-slot and a 6-slot instance.
module tb_inorder_bitvector_drain;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 64-slot instance
  logic        rst;
  logic [63:0] vb;
  logic        clear_val, drain_val, drain_rdy, restart_val, head_wrap;
  logic [5:0]  clear_index, drain_index, restart_index, head_ptr;

  // 6-slot instance
  logic        rst6;
  logic [5:0]  vb6;
  logic        clear_val6, drain_val6, drain_rdy6, restart_val6, head_wrap6;
  logic [2:0]  clear_index6, drain_index6, restart_index6, head_ptr6;

  int checks = 0;
  int errors = 0;

  inorder_bitvector_drain #(.BITVECTOR_SIZE(64)) dut (
    .clk(clk), .rst(rst), .valid_bitvector(vb),
    .clear_val(clear_val), .clear_index(clear_index),
    .drain_val(drain_val), .drain_index(drain_index), .drain_rdy(drain_rdy),
    .restart_val(restart_val), .restart_index(restart_index),
    .head_ptr(head_ptr), .head_wrap(head_wrap)
  );

  inorder_bitvector_drain #(.BITVECTOR_SIZE(6)) dut6 (
    .clk(clk), .rst(rst6), .valid_bitvector(vb6),
    .clear_val(clear_val6), .clear_index(clear_index6),
    .drain_val(drain_val6), .drain_index(drain_index6), .drain_rdy(drain_rdy6),
    .restart_val(restart_val6), .restart_index(restart_index6),
    .head_ptr(head_ptr6), .head_wrap(head_wrap6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the presented slot on the 64-slot instance; the writer clears the bit.
  task automatic accept64(input int idx);
    drain_rdy = 1'b1;
    #1;
    check("clear_val_hs", 32'(clear_val), 32'd1);
    check("clear_index_hs", 32'(clear_index), 32'(idx));
    tick();
    drain_rdy = 1'b0;
    vb[idx]   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; vb = '0; drain_rdy = 1'b0; restart_val = 1'b0; restart_index = '0;
    rst6 = 1'b0; vb6 = '0; drain_rdy6 = 1'b0; restart_val6 = 1'b0; restart_index6 = '0;
    tick();
    tick();
    check("rst_drain_val", 32'(drain_val), 32'd0);
    check("rst_clear_val", 32'(clear_val), 32'd0);
    check("rst_head_ptr", 32'(head_ptr), 32'd0);
    check("rst_head_wrap", 32'(head_wrap), 32'd0);
    check("rst_drain_index", 32'(drain_index), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_drain_val", 32'(drain_val), 32'd0);

    // Slot 0 set: presented one cycle later, accepted, head advances.
    vb[0] = 1'b1;
    #1;
    check("pre_latch_drain_val", 32'(drain_val), 32'd0);
    tick();
    check("s0_drain_val", 32'(drain_val), 32'd1);
    check("s0_drain_index", 32'(drain_index), 32'd0);
    accept64(0);
    check("s0_head_ptr", 32'(head_ptr), 32'd1);
    check("s0_after_clear", 32'(clear_val), 32'd0);
    check("s0_after_drain_val", 32'(drain_val), 32'd0);

    // Back to head 0, set slots 2 and 1 before slot 0.
    restart_val = 1'b1; restart_index = 6'd0;
    tick();
    restart_val = 1'b0;
    check("rs0_head_ptr", 32'(head_ptr), 32'd0);
    vb[2] = 1'b1;
    tick();
    check("hold_s2_drain_val", 32'(drain_val), 32'd0);
    vb[1] = 1'b1;
    tick();
    check("hold_s1_drain_val", 32'(drain_val), 32'd0);
    tick();
    check("hold_s1b_drain_val", 32'(drain_val), 32'd0);
    vb[0] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ord_drain_val", 32'(drain_val), 32'd1);
      check("ord_drain_index", 32'(drain_index), 32'(i));
      accept64(i);
      tick();
    end
    check("ord_head_ptr", 32'(head_ptr), 32'd3);
    check("ord_empty_drain_val", 32'(drain_val), 32'd0);

    // Stall for 10 cycles; the bit drops midway and the slot is still presented.
    vb[3] = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) vb[3] = 1'b0;
      tick();
      check("stall_drain_val", 32'(drain_val), 32'd1);
      check("stall_drain_index", 32'(drain_index), 32'd3);
      check("stall_clear_val", 32'(clear_val), 32'd0);
    end
    accept64(3);
    check("stall_head_ptr", 32'(head_ptr), 32'd4);

    // Restart coincident with handshake: no clear, head loaded, back to WAIT.
    vb[4] = 1'b1;
    tick();
    check("rsh_drain_index", 32'(drain_index), 32'd4);
    drain_rdy = 1'b1; restart_val = 1'b1; restart_index = 6'd7;
    #1;
    check("rsh_clear_val", 32'(clear_val), 32'd0);
    tick();
    drain_rdy = 1'b0; restart_val = 1'b0; vb[4] = 1'b0;
    check("rsh_head_ptr", 32'(head_ptr), 32'd7);
    check("rsh_head_wrap", 32'(head_wrap), 32'd0);
    check("rsh_drain_val", 32'(drain_val), 32'd0);
    tick();
    check("rsh_wait_drain_val", 32'(drain_val), 32'd0);

    // Reset in PRESENT abandons slot 7; slot 0 re-presented from head 0.
    vb[7] = 1'b1; vb[0] = 1'b1;
    tick();
    check("rp_drain_index", 32'(drain_index), 32'd7);
    rst = 1'b0; drain_rdy = 1'b1;
    #1;
    check("rp_cycle_drain_val", 32'(drain_val), 32'd0);
    check("rp_cycle_clear_val", 32'(clear_val), 32'd0);
    tick();
    check("rp_drain_val", 32'(drain_val), 32'd0);
    check("rp_clear_val", 32'(clear_val), 32'd0);
    check("rp_head_ptr", 32'(head_ptr), 32'd0);
    check("rp_drain_index", 32'(drain_index), 32'd0);
    check("rp_head_wrap", 32'(head_wrap), 32'd0);
    rst = 1'b1; drain_rdy = 1'b0;
    tick();
    check("rp_re_drain_val", 32'(drain_val), 32'd1);
    check("rp_re_drain_index", 32'(drain_index), 32'd0);

    // 6-slot instance: drain all six, head wraps 5 -> 0 and epoch toggles.
    rst6 = 1'b1;
    vb6  = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("w6_drain_val", 32'(drain_val6), 32'd1);
      check("w6_drain_index", 32'(drain_index6), 32'(i));
      check("w6_head_wrap_pre", 32'(head_wrap6), 32'd0);
      drain_rdy6 = 1'b1;
      #1;
      check("w6_clear_index", 32'(clear_index6), 32'(i));
      tick();
      drain_rdy6 = 1'b0;
      vb6[i] = 1'b0;
    end
    check("w6_head_ptr", 32'(head_ptr6), 32'd0);
    check("w6_head_wrap", 32'(head_wrap6), 32'd1);

    // Out-of-range restart index maps to slot 0 and clears the epoch.
    restart_val6 = 1'b1; restart_index6 = 3'd7;
    tick();
    restart_val6 = 1'b0;
    check("w6_rs_head_ptr", 32'(head_ptr6), 32'd0);
    check("w6_rs_head_wrap", 32'(head_wrap6), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inorder_bitvector_drain.md
INORDER_BITVECTOR_DRAIN -- requirements
Module: inorder_bitvector_drain

Interface
REQ-001 SHALL have parameter BITVECTOR_SIZE, default 64: number of slots tracked; any value >= 2, not necessarily a power of two.
REQ-002 SHALL have parameter BITVECTOR_INDEX_W, default $clog2(BITVECTOR_SIZE): slot index width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port valid_bitvector, input, BITVECTOR_SIZE: registered per-slot valid bits from the slot writer.
REQ-006 SHALL have port clear_val, output, 1: one-cycle pulse that clears a slot in the writer.
REQ-007 SHALL have port clear_index, output, BITVECTOR_INDEX_W: slot cleared when clear_val=1.
REQ-008 SHALL have port drain_val, output, 1: drained slot index is presented.
REQ-009 SHALL have port drain_index, output, BITVECTOR_INDEX_W: presented slot index.
REQ-010 SHALL have port drain_rdy, input, 1: consumer accepts the presented index.
REQ-011 SHALL have port restart_val, input, 1: load a new head pointer.
REQ-012 SHALL have port restart_index, input, BITVECTOR_INDEX_W: new head value.
REQ-013 SHALL have port head_ptr, output, BITVECTOR_INDEX_W: current head slot.
REQ-014 SHALL have port head_wrap, output, 1: epoch bit, toggled on each head wrap.

Function
REQ-015 SHALL drain slots strictly in index order starting at head_ptr, never skipping a slot whose bit is clear.
REQ-016 SHALL implement two states: WAIT (head bit not yet latched) and PRESENT (drain_val=1).
REQ-017 In WAIT, when valid_bitvector[head_ptr]=1, SHALL register drain_index<=head_ptr and enter PRESENT next cycle; one-cycle latency from bit visible to drain_val.
REQ-018 In PRESENT, drain_val SHALL be 1 and drain_index SHALL hold stable until drain_rdy=1.
REQ-019 On drain_val&drain_rdy, SHALL assert clear_val=1 combinationally in that same cycle with clear_index=drain_index, advance head_ptr, and return to WAIT.
REQ-020 Head advance SHALL wrap from BITVECTOR_SIZE-1 to 0 explicitly (not by bit-width overflow) and toggle head_wrap on that wrap.
REQ-021 clear_val SHALL be 0 in every cycle without a handshake; at most one clear per cycle.
REQ-022 SHALL sample valid_bitvector only at head_ptr; other bits have no effect.
REQ-023 restart_val SHALL take priority in any state: head_ptr<=restart_index, head_wrap<=0, state<=WAIT, no clear_val issued even if drain_rdy=1 in that cycle.
REQ-024 restart_index >= BITVECTOR_SIZE SHALL be treated as 0.
REQ-025 When a bit drops while in PRESENT without a handshake, SHALL keep presenting; the handshake alone retires the slot.

Reset
REQ-026 While rst=0 at a clock edge: state<=WAIT, head_ptr<=0, head_wrap<=0, drain_index<=0; drain_val and clear_val SHALL be 0 in the reset cycle.
REQ-027 Reset asserted mid-PRESENT SHALL abandon the pending index with no clear issued.

Structure
REQ-028 The WAIT/PRESENT state enum SHALL live in the shared valid_bitvector_pkg alongside other bitvector typedefs; no other constants are needed.
REQ-029 SHALL contain no sub-modules; the parent instantiates valid_bitvector and connects its valid_bitvector output and clear port to this block.

Verification
REQ-030 Reset, set slot 0 -> drain_val=1 one cycle after the bit is visible, drain_index=0; drain_rdy=1 -> clear_val=1, clear_index=0, head_ptr=1 next cycle.
REQ-031 Set slots 2 and 1 before 0 (SIZE=64) -> drains in order 0,1,2, nothing presented while slot 0 clear.
REQ-032 SIZE=6, drain 6 slots -> head_ptr 5 wraps to 0, head_wrap toggles 0->1.
REQ-033 Hold drain_rdy=0 for 10 cycles in PRESENT -> drain_val and drain_index stable, clear_val=0 throughout.
REQ-034 restart_val=1, restart_index=7 coincident with drain_rdy=1 -> no clear_val, head_ptr=7, head_wrap=0, state WAIT.
REQ-035 rst=0 during PRESENT -> all outputs 0 next cycle; after release the same slot is re-presented from head 0.
